shift_register: RTL and testbench

//  Parallel-in / serial-out shift register with serial fill input.
//  A word is loaded in parallel, then shifted out one bit per clock, MSB first by default.

---
 rtl/shift_register.sv | 55 +++++
 tb/tb_shift_register.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Parallel-in / serial-out shift register with serial fill and a remaining-bit counter.
// The serial output, contents and empty flag come straight from the state registers.
module shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] q,
  output logic             empty
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Load wins over shift; the counter saturates at zero while shifting continues.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = in;
      cnt_d = CW'(WIDTH);
    end else begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], si};
      end else begin
        sr_d = {si, sr_q[WIDTH-1:1]};
      end
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign so    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign q     = sr_q;
  assign empty = (cnt_q == '0);

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: MSB-first instance plus an LSB-first instance.
module tb_shift_register;

  logic       clk;
  logic       resetq;
  logic       load;
  logic [7:0] in;
  logic       si;
  logic       so_m, so_l;
  logic [7:0] q_m, q_l;
  logic       empty_m, empty_l;

  int checks;
  int errors;

  shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .resetq(resetq), .load(load), .in(in), .si(si),
    .so(so_m), .q(q_m), .empty(empty_m)
  );

  shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .resetq(resetq), .load(load), .in(in), .si(si),
    .so(so_l), .q(q_l), .empty(empty_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load = 1'b1;
    in   = w;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    resetq = 1'b0; load = 1'b0; in = 8'h00; si = 1'b0;
    #2;
    checks++;
    if ({so_m, q_m, empty_m} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_initial so=%0b q=%h empty=%0b want so=0 q=00 empty=1", so_m, q_m, empty_m);
    end
    resetq = 1'b1;
    load_word(8'hFF);
    tick();
    // Asynchronous assertion mid-cycle, no clock edge in between.
    #2 resetq = 1'b0;
    #1;
    checks++;
    if ({so_m, q_m, empty_m} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_async so=%0b q=%h empty=%0b want so=0 q=00 empty=1", so_m, q_m, empty_m);
    end
    si = 1'b1;
    tick();
    checks++;
    if ({q_m, empty_m} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_held q=%h empty=%0b want q=00 empty=1", q_m, empty_m);
    end
    @(negedge clk) resetq = 1'b1;
    tick();
    checks++;
    if ({q_m, so_m, empty_m} !== {8'h01, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release_shift q=%h so=%0b empty=%0b want q=01 so=0 empty=1", q_m, so_m, empty_m);
    end
  endtask

  task automatic test_serialize();
    logic [7:0] exp_so;
    logic [7:0] exp_q [8];
    exp_so = 8'b1010_1110;
    exp_q  = '{8'hAE, 8'h5C, 8'hB8, 8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00};
    si = 1'b0;
    load_word(8'hAE);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (so_m !== exp_so[7-k] || q_m !== exp_q[k] || empty_m !== 1'b0) begin
        errors++;
        $display("FAIL serialize bit%0d so=%0b q=%h empty=%0b want so=%0b q=%h empty=0",
                 k, so_m, q_m, empty_m, exp_so[7-k], exp_q[k]);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    // Continues from test_serialize: eight shifts with si=0 are done.
    checks++;
    if ({q_m, so_m, empty_m} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fill_8 q=%h so=%0b empty=%0b want q=00 so=0 empty=1", q_m, so_m, empty_m);
    end
    si = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if ({q_m, so_m, empty_m} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL fill_16 q=%h so=%0b empty=%0b want q=FF so=1 empty=1", q_m, so_m, empty_m);
    end
    si = 1'b0;
  endtask

  task automatic test_reload_mid_shift();
    logic [7:0] exp_so;
    exp_so = 8'h5A;
    si = 1'b0;
    load_word(8'hAE);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (q_m !== 8'h70) begin
      errors++;
      $display("FAIL reload_pre q=%h want 70", q_m);
    end
    load_word(8'h5A);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (so_m !== exp_so[7-k] || empty_m !== 1'b0) begin
        errors++;
        $display("FAIL reload bit%0d so=%0b empty=%0b want so=%0b empty=0", k, so_m, empty_m, exp_so[7-k]);
      end
      tick();
    end
    checks++;
    if (empty_m !== 1'b1) begin
      errors++;
      $display("FAIL reload_empty empty=%0b want 1", empty_m);
    end
  endtask

  task automatic test_load_held();
    load = 1'b1;
    in   = 8'hAE;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({q_m, so_m, empty_m} !== {8'hAE, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL load_held edge%0d q=%h so=%0b empty=%0b want q=AE so=1 empty=0", k, q_m, so_m, empty_m);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_so;
    exp_so = 8'b0111_0101;
    si = 1'b0;
    load_word(8'hAE);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (so_l !== exp_so[7-k] || empty_l !== 1'b0) begin
        errors++;
        $display("FAIL lsb_first bit%0d so=%0b empty=%0b want so=%0b empty=0", k, so_l, empty_l, exp_so[7-k]);
      end
      tick();
    end
    checks++;
    if ({q_l, empty_l} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL lsb_first_done q=%h empty=%0b want q=00 empty=1", q_l, empty_l);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_serialize();
    test_fill();
    test_reload_mid_shift();
    test_load_held();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
